// File: rtl/prog_loader.sv
// Framed program loader: buffers SYNC/LEN/payload/CSUM frames, validates the checksum,
// and only then streams the buffered opcodes into the downstream instruction FIFO.
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    input  logic                  fifo_full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code
);
    localparam int MAXLEN = 2 ** ADDR_WIDTH;
    localparam int TCW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TCW-1:0]        T_LAST   = TCW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH:0]   MAXLEN_D = (DATA_WIDTH + 1)'(MAXLEN);
    localparam logic [DATA_WIDTH-1:0] SYNC     = DATA_WIDTH'(8'hA5);

    typedef enum logic [2:0] {IDLE, GET_LEN, PAYLOAD, CSUM, COMMIT} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH:0]   idx_reg;
    logic [ADDR_WIDTH:0]   len_reg;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic [TCW-1:0]        tcnt_reg;
    logic [DATA_WIDTH-1:0] buffer [MAXLEN];

    logic xfer;
    logic last;
    logic in_frame;
    logic len_ok;

    assign rx_ready = (state_reg != COMMIT);
    assign busy     = (state_reg != IDLE);
    assign xfer     = rx_valid && rx_ready;
    assign last     = (idx_reg == len_reg - 1'b1);
    assign in_frame = (state_reg == GET_LEN) || (state_reg == PAYLOAD) || (state_reg == CSUM);
    assign len_ok   = (rx_data != '0) && ({1'b0, rx_data} <= MAXLEN_D);

    // Writes are combinational so a deasserted fifo_full is used in the very same cycle.
    assign wr     = (state_reg == COMMIT) && !fifo_full;
    assign opcode = wr ? buffer[idx_reg[ADDR_WIDTH-1:0]] : '0;

    // Payload buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state_reg == PAYLOAD && xfer) begin
            buffer[idx_reg[ADDR_WIDTH-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            len_reg   <= '0;
            sum_reg   <= '0;
            tcnt_reg  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (in_frame && !xfer) begin
                if (tcnt_reg == T_LAST) begin
                    load_err  <= 1'b1;
                    err_code  <= 2'b11;
                    state_reg <= IDLE;
                    tcnt_reg  <= '0;
                end else begin
                    tcnt_reg <= tcnt_reg + 1'b1;
                end
            end else begin
                tcnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (xfer && rx_data == SYNC) begin
                            state_reg <= GET_LEN;
                            err_code  <= 2'b00;
                        end
                    end
                    GET_LEN: begin
                        if (len_ok) begin
                            len_reg   <= rx_data[ADDR_WIDTH:0];
                            idx_reg   <= '0;
                            sum_reg   <= '0;
                            state_reg <= PAYLOAD;
                        end else begin
                            load_err  <= 1'b1;
                            err_code  <= 2'b01;
                            state_reg <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        sum_reg <= sum_reg + rx_data;
                        idx_reg <= idx_reg + 1'b1;
                        if (last) begin
                            state_reg <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (rx_data == sum_reg) begin
                            idx_reg   <= '0;
                            state_reg <= COMMIT;
                        end else begin
                            load_err  <= 1'b1;
                            err_code  <= 2'b10;
                            state_reg <= IDLE;
                        end
                    end
                    COMMIT: begin
                        if (!fifo_full) begin
                            idx_reg <= idx_reg + 1'b1;
                            if (last) begin
                                load_done <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the byte stream and opcode path.
REQ-002 Parameter ADDR_WIDTH, default 4; max program length MAXLEN = 2**ADDR_WIDTH (16), equal to the instruction FIFO depth.
REQ-003 Parameter TIMEOUT, default 255, idle cycles allowed between bytes inside a frame.
REQ-004 Ports (name direction width meaning): clk in 1 clock; reset in 1 asynchronous active-low reset; rx_valid in 1 byte available; rx_data in DATA_WIDTH byte; rx_ready out 1 loader accepts byte; fifo_full in 1 instruction FIFO full; wr out 1 FIFO write strobe; opcode out DATA_WIDTH FIFO write data; busy out 1 frame in progress; load_done out 1 one-cycle success pulse; load_err out 1 one-cycle error pulse; err_code out 2 last error cause.
REQ-005 One clock; reset is asynchronous and active-low.

Function
REQ-006 Upstream of the instruction FIFO: receives a framed program byte stream, buffers it, validates it, and only then writes opcodes into the FIFO.
REQ-007 Frame: SYNC (0xA5), LEN, LEN payload bytes, CSUM; CSUM = 8-bit sum mod 256 of the payload bytes (LEN and SYNC excluded).
REQ-008 Byte transfer occurs on a rising clk edge where rx_valid && rx_ready; rx_data is don't-care otherwise.
REQ-009 States: IDLE, GET_LEN, PAYLOAD, CSUM, COMMIT.
REQ-010 rx_ready = 1 in IDLE, GET_LEN, PAYLOAD, CSUM; rx_ready = 0 in COMMIT.
REQ-011 IDLE: byte 0xA5 -> GET_LEN and clear err_code to 00; any other byte discarded, stay IDLE.
REQ-012 GET_LEN: LEN in 1..MAXLEN -> store len, clear index and sum, -> PAYLOAD; LEN 0 or > MAXLEN -> load_err, err_code 01, -> IDLE.
REQ-013 PAYLOAD: each byte written to internal buffer[index], sum += byte (mod 256), index++; acceptance of byte number len -> CSUM.
REQ-014 CSUM: byte == sum -> COMMIT with index cleared; mismatch -> load_err, err_code 10, -> IDLE; FIFO untouched on any error.
REQ-015 COMMIT: wr = 1 combinationally exactly in cycles where state is COMMIT and fifo_full = 0; opcode = buffer[index] in those cycles; index++ on each such cycle.
REQ-016 fifo_full = 1 in COMMIT: wr = 0, index held, no data lost; write resumes in the first cycle fifo_full = 0.
REQ-017 After the len-th write -> IDLE, with load_done = 1 for exactly the following cycle.
REQ-018 Timeout: in GET_LEN, PAYLOAD or CSUM, a counter counts cycles without a transfer, cleared on each transfer; reaching TIMEOUT -> load_err, err_code 11, -> IDLE. No timeout in COMMIT.
REQ-019 A 0xA5 byte inside GET_LEN/PAYLOAD/CSUM is data, not resync.
REQ-020 busy = 1 in every state except IDLE.
REQ-021 load_err and load_done are registered one-cycle pulses, never simultaneous; err_code holds until the next accepted SYNC.
REQ-022 wr = 0 and opcode = 0 outside COMMIT.

Reset
REQ-023 reset low asynchronously forces IDLE, index/len/sum/timeout = 0, load_done = load_err = 0, err_code = 00, wr = 0, busy = 0; buffer contents need not be cleared.
REQ-024 Reset mid-COMMIT abandons remaining writes; no wr after reset asserts; bytes already written stay in the FIFO.
REQ-025 After reset release, first active edge operates normally from IDLE.

Verification
REQ-026 Frame A5 03 11 22 33 66, fifo_full=0 -> 3 consecutive wr cycles with opcode 11,22,33, then load_done pulse, err_code 00.
REQ-027 Frame A5 02 10 20 31 -> load_err, err_code 10, wr never asserted, next valid frame loads normally.
REQ-028 Bytes 00 A5 00 then A5 11 -> first 00 discarded; LEN 00 -> err_code 01; LEN 11 (17) -> err_code 01.
REQ-029 Frame A5 04 01 02 03 04 0A with fifo_full held 1 for 5 cycles after the 2nd write -> opcode sequence 01..04 intact, wr low while full, single load_done.
REQ-030 A5 02 7F then rx_valid low for TIMEOUT cycles -> load_err, err_code 11, busy 0; 16-byte frame with sum wrap (e.g. 16 x FF, CSUM F0) -> 16 writes, load_done.
REQ-031 reset low during COMMIT after 1 of 3 writes -> wr 0 immediately, busy 0, err_code 00, no load_done.
